// File: rtl/uart_rx_param.sv
// UART receive engine: internal baud tick, oversampled majority-vote bit
// sampling, 5..9 data bits, optional parity, 1 or 2 stop bits, and a
// single-entry holding register with a valid/ready handshake.
module uart_rx_param #(
  parameter int unsigned CLOCK_RATE  = 100000000,
  parameter int unsigned BAUD_RATE   = 9600,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_en,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int unsigned DIV_RAW = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SAMP_W  = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W   = $clog2(DATA_BITS + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
  localparam logic [SAMP_W-1:0] SAMP_A    = SAMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMP_W-1:0] SAMP_B    = SAMP_W'(OVERSAMPLE / 2);
  localparam logic [SAMP_W-1:0] SAMP_C    = SAMP_W'(OVERSAMPLE / 2 + 1);
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);
  localparam logic [SAMP_W-1:0] SAMP_ONE  = SAMP_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
  localparam logic              STOP_LAST = (STOP_BITS == 2);
  localparam logic              ODD_PAR   = (PARITY_MODE == 2);
  localparam logic              HAS_PAR   = (PARITY_MODE != 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [SAMP_W-1:0]     samp_q, samp_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic                  s_a_q, s_a_d;
  logic                  s_b_q, s_b_d;
  logic [DATA_BITS-1:0]  shreg_q, shreg_d;
  logic                  par_flag_q, par_flag_d;
  logic                  frm_flag_q, frm_flag_d;

  logic                  meta_q, sync_q, prev_q;

  logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  fe_q, fe_d;
  logic                  pe_q, pe_d;
  logic                  ovr_q, ovr_d;

  logic                  tick;
  logic                  at_a, at_b, decide, bit_end;
  logic                  maj;
  logic                  fall;
  logic                  par_exp;
  logic                  done;

  assign tick    = (div_q == DIV_LAST);
  assign at_a    = tick && (samp_q == SAMP_A);
  assign at_b    = tick && (samp_q == SAMP_B);
  assign decide  = tick && (samp_q == SAMP_C);
  assign bit_end = tick && (samp_q == SAMP_LAST);
  assign maj     = (s_a_q & s_b_q) | (s_a_q & sync_q) | (s_b_q & sync_q);
  assign fall    = prev_q & ~sync_q;
  assign par_exp = (^shreg_q) ^ ODD_PAR;

  // Line synchronizer and falling-edge history; preset high to match an idle line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rxd;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  // Frame state machine, tick/sample counters and shift register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      samp_q     <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      s_a_q      <= 1'b1;
      s_b_q      <= 1'b1;
      shreg_q    <= '0;
      par_flag_q <= 1'b0;
      frm_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      samp_q     <= samp_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      s_a_q      <= s_a_d;
      s_b_q      <= s_b_d;
      shreg_q    <= shreg_d;
      par_flag_q <= par_flag_d;
      frm_flag_q <= frm_flag_d;
    end
  end

  // Next-state logic: counters idle at zero so bit phase starts at the detected edge.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shreg_d    = shreg_q;
    par_flag_d = par_flag_q;
    frm_flag_d = frm_flag_q;
    s_a_d      = at_a ? sync_q : s_a_q;
    s_b_d      = at_b ? sync_q : s_b_q;
    done       = 1'b0;

    if (state_q == ST_IDLE) begin
      div_d  = '0;
      samp_d = '0;
    end else begin
      div_d  = tick ? '0 : div_q + DIV_ONE;
      samp_d = samp_q;
      if (tick) begin
        samp_d = (samp_q == SAMP_LAST) ? '0 : samp_q + SAMP_ONE;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (rx_en && fall) begin
          state_d    = ST_START;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          par_flag_d = 1'b0;
          frm_flag_d = 1'b0;
        end
      end
      ST_START: begin
        if (decide && maj) begin
          state_d = ST_IDLE;
        end else if (bit_end) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (decide) begin
          shreg_d   = {maj, shreg_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BIT_ONE;
        end
        if (bit_end && (bit_cnt_q == BIT_LAST)) begin
          state_d = HAS_PAR ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (decide && (maj != par_exp)) begin
          par_flag_d = 1'b1;
        end
        if (bit_end) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (decide) begin
          if (!maj) begin
            frm_flag_d = 1'b1;
          end
          // The last stop bit completes the frame at its decision tick, not at
          // bit end, so a following start edge can be caught mid-stop-bit.
          if (stop_cnt_q == STOP_LAST) begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!rx_en && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      done    = 1'b0;
    end
  end

  // Holding register, status flags and overrun pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      fe_q       <= 1'b0;
      pe_q       <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      fe_q       <= fe_d;
      pe_q       <= pe_d;
      ovr_q      <= ovr_d;
    end
  end

  // Load a completed frame when the slot is free or being read; otherwise drop it.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    fe_d       = fe_q;
    pe_d       = pe_q;
    ovr_d      = 1'b0;
    if (done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shreg_q;
        fe_d       = frm_flag_d;
        pe_d       = par_flag_q;
        rx_valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = fe_q;
  assign parity_err  = pe_q;
  assign overrun_err = ovr_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: four instances (8N1, 8E1, 8O1, 8N2) at 64 clk/bit,
// expected words queued as frames are driven, accepted words queued by a monitor.
module tb_uart_rx_param;

  localparam int BIT_CLK = 64;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } word_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_en = 1'b1;
  logic rxd = 1'b1;
  logic rx_ready = 1'b1;

  logic [7:0] data_a  [4];
  logic       valid_a [4];
  logic       fe_a    [4];
  logic       pe_a    [4];
  logic       ov_a    [4];
  logic       busy_a  [4];

  int sel = 0;
  logic [7:0] m_data;
  logic m_valid, m_fe, m_pe, m_ov, m_busy;

  word_t exp_q[$];
  word_t obs_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int valid_cycles = 0;
  int ovr_cycles = 0;

  always #5 clk = ~clk;

  uart_rx_param #(.CLOCK_RATE(640000), .BAUD_RATE(10000), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .rx_en(rx_en), .rxd(rxd), .rx_data(data_a[0]),
    .rx_valid(valid_a[0]), .rx_ready(rx_ready), .frame_err(fe_a[0]),
    .parity_err(pe_a[0]), .overrun_err(ov_a[0]), .busy(busy_a[0]));

  uart_rx_param #(.CLOCK_RATE(640000), .BAUD_RATE(10000), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst_n(rst_n), .rx_en(rx_en), .rxd(rxd), .rx_data(data_a[1]),
    .rx_valid(valid_a[1]), .rx_ready(rx_ready), .frame_err(fe_a[1]),
    .parity_err(pe_a[1]), .overrun_err(ov_a[1]), .busy(busy_a[1]));

  uart_rx_param #(.CLOCK_RATE(640000), .BAUD_RATE(10000), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst_n(rst_n), .rx_en(rx_en), .rxd(rxd), .rx_data(data_a[2]),
    .rx_valid(valid_a[2]), .rx_ready(rx_ready), .frame_err(fe_a[2]),
    .parity_err(pe_a[2]), .overrun_err(ov_a[2]), .busy(busy_a[2]));

  uart_rx_param #(.CLOCK_RATE(640000), .BAUD_RATE(10000), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .rst_n(rst_n), .rx_en(rx_en), .rxd(rxd), .rx_data(data_a[3]),
    .rx_valid(valid_a[3]), .rx_ready(rx_ready), .frame_err(fe_a[3]),
    .parity_err(pe_a[3]), .overrun_err(ov_a[3]), .busy(busy_a[3]));

  always_comb begin
    m_data  = data_a[sel];
    m_valid = valid_a[sel];
    m_fe    = fe_a[sel];
    m_pe    = pe_a[sel];
    m_ov    = ov_a[sel];
    m_busy  = busy_a[sel];
  end

  // Monitor: record words accepted by the consumer and count pulse widths.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid) valid_cycles++;
      if (m_valid && rx_ready) obs_q.push_back({m_data, m_fe, m_pe});
      if (m_ov) ovr_cycles++;
    end
  end

  task automatic drive(input logic b, input int n);
    rxd = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int s);
    rxd = 1'b1;
    rx_en = 1'b1;
    rx_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sel = s;
    exp_q.delete();
    obs_q.delete();
    valid_cycles = 0;
    ovr_cycles = 0;
    drive(1'b1, 16);
  endtask

  // glitch_bit >= 0 inserts a 1-clk low pulse on the middle sample of that data bit.
  task automatic send_frame(input logic [7:0] data, input bit has_par, input logic pbit,
                            input int nstop, input logic s1, input logic s2,
                            input int glitch_bit, input int stop_len);
    drive(1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch_bit) begin
        drive(data[i], 36);
        drive(1'b0, 1);
        drive(data[i], BIT_CLK - 37);
      end else begin
        drive(data[i], BIT_CLK);
      end
    end
    if (has_par) drive(pbit, BIT_CLK);
    if (nstop == 2) begin
      drive(s1, BIT_CLK);
      drive(s2, stop_len);
    end else begin
      drive(s1, stop_len);
    end
    rxd = 1'b1;
  endtask

  task automatic send_partial(input logic [7:0] data);
    drive(1'b0, BIT_CLK);
    for (int i = 0; i < 4; i++) drive(data[i], BIT_CLK);
    drive(data[4], 30);
  endtask

  task automatic test_reset();
    do_reset(0);
    @(negedge clk);
    n_cmp++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", m_data); end
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", m_valid); end
    n_cmp++; if (m_fe !== 1'b0) begin n_fail++; $display("FAIL reset_fe: got %b want 0", m_fe); end
    n_cmp++; if (m_pe !== 1'b0) begin n_fail++; $display("FAIL reset_pe: got %b want 0", m_pe); end
    n_cmp++; if (m_ov !== 1'b0) begin n_fail++; $display("FAIL reset_ov: got %b want 0", m_ov); end
    n_cmp++; if (m_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", m_busy); end
  endtask

  task automatic test_basic();
    word_t o, e;
    do_reset(0);
    exp_q.push_back('{d: 8'hA5, fe: 1'b0, pe: 1'b0});
    fork
      send_frame(8'hA5, 1'b0, 1'b0, 1, 1'b1, 1'b1, -1, BIT_CLK);
      begin
        repeat (200) @(negedge clk);
        n_cmp++; if (m_busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_mid: got %b want 1", m_busy); end
      end
    join
    repeat (10) @(negedge clk);
    n_cmp++; if (m_busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b want 0", m_busy); end
    n_cmp++; if (valid_cycles !== 1) begin n_fail++; $display("FAIL basic_valid_width: got %0d cycles want 1", valid_cycles); end
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL basic_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL basic_word: got %h/%b/%b want %h/%b/%b", o.d, o.fe, o.pe, e.d, e.fe, e.pe); end
    end
  endtask

  task automatic test_parity();
    word_t o, e;
    logic [7:0] dv;
    logic pb;
    for (int mode = 1; mode <= 2; mode++) begin
      do_reset(mode);
      for (int k = 0; k < 3; k++) begin
        dv = (k == 2) ? 8'hB7 : 8'h03;
        pb = (k == 1) ? 1'b0 : 1'b1;
        // even: total ones must be even; odd: total ones must be odd
        exp_q.push_back('{d: dv, fe: 1'b0,
                          pe: ((^{dv, pb}) != ((mode == 2) ? 1'b1 : 1'b0))});
        send_frame(dv, 1'b1, pb, 1, 1'b1, 1'b1, -1, BIT_CLK);
      end
      repeat (10) @(negedge clk);
      n_cmp++;
      if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL parity_count mode %0d: got %0d want %0d", mode, obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
        o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
        if (o !== e) begin n_fail++; $display("FAIL parity_word mode %0d: got %h/%b/%b want %h/%b/%b", mode, o.d, o.fe, o.pe, e.d, e.fe, e.pe); end
      end
    end
  endtask

  task automatic test_framing();
    word_t o, e;
    logic s1v [4];
    logic s2v [4];
    int ns;
    s1v = '{1'b0, 1'b1, 1'b1, 1'b0};
    s2v = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int dut = 0; dut < 4; dut += 3) begin
      do_reset(dut);
      ns = (dut == 3) ? 2 : 1;
      for (int k = 0; k < 4; k++) begin
        if (ns == 1 && k > 1) continue;
        exp_q.push_back('{d: 8'h55, pe: 1'b0,
                          fe: (ns == 2) ? !(s1v[k] && s2v[k]) : !s1v[k]});
        send_frame(8'h55, 1'b0, 1'b0, ns, s1v[k], s2v[k], -1, BIT_CLK);
        drive(1'b1, 16);
      end
      repeat (10) @(negedge clk);
      n_cmp++;
      if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL frame_count dut %0d: got %0d want %0d", dut, obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
        o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
        if (o !== e) begin n_fail++; $display("FAIL frame_word dut %0d: got %h/%b/%b want %h/%b/%b", dut, o.d, o.fe, o.pe, e.d, e.fe, e.pe); end
      end
    end
  endtask

  task automatic test_overrun();
    word_t o, e;
    do_reset(0);
    rx_ready = 1'b0;
    exp_q.push_back('{d: 8'h11, fe: 1'b0, pe: 1'b0});
    send_frame(8'h11, 1'b0, 1'b0, 1, 1'b1, 1'b1, -1, BIT_CLK);
    send_frame(8'h22, 1'b0, 1'b0, 1, 1'b1, 1'b1, -1, BIT_CLK);
    repeat (5) @(negedge clk);
    n_cmp++; if (ovr_cycles !== 1) begin n_fail++; $display("FAIL ovr_width: got %0d cycles want 1", ovr_cycles); end
    n_cmp++; if (m_data !== 8'h11) begin n_fail++; $display("FAIL ovr_held: got %h want 11", m_data); end
    n_cmp++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %b want 1", m_valid); end
    @(posedge clk); #1;
    rx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_drain: got %b want 0", m_valid); end
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL ovr_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL ovr_word: got %h/%b/%b want %h/%b/%b", o.d, o.fe, o.pe, e.d, e.fe, e.pe); end
    end
  endtask

  task automatic test_glitch();
    word_t o, e;
    do_reset(0);
    drive(1'b0, 20);
    drive(1'b1, 200);
    n_cmp++; if (valid_cycles !== 0) begin n_fail++; $display("FAIL glitch_valid: got %0d cycles want 0", valid_cycles); end
    n_cmp++; if (m_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy: got %b want 0", m_busy); end
    n_cmp++; if ({m_fe, m_pe, m_ov} !== 3'b000) begin n_fail++; $display("FAIL glitch_flags: got %b want 000", {m_fe, m_pe, m_ov}); end
    exp_q.push_back('{d: 8'hA5, fe: 1'b0, pe: 1'b0});
    send_frame(8'hA5, 1'b0, 1'b0, 1, 1'b1, 1'b1, 2, BIT_CLK);
    repeat (10) @(negedge clk);
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL glitch_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL glitch_word: got %h/%b/%b want %h/%b/%b", o.d, o.fe, o.pe, e.d, e.fe, e.pe); end
    end
  endtask

  task automatic test_abort();
    word_t o, e;
    for (int v = 0; v < 2; v++) begin
      do_reset(0);
      send_partial(8'h7E);
      if (v == 0) rx_en = 1'b0;
      else rst_n = 1'b0;
      rxd = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_cmp++; if (m_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy v%0d: got %b want 0", v, m_busy); end
      n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid v%0d: got %b want 0", v, m_valid); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      drive(1'b1, 100);
      rx_en = 1'b1;
      drive(1'b1, 10);
      n_cmp++; if (valid_cycles !== 0) begin n_fail++; $display("FAIL abort_novalid v%0d: got %0d cycles want 0", v, valid_cycles); end
      exp_q.push_back('{d: 8'h7E, fe: 1'b0, pe: 1'b0});
      send_frame(8'h7E, 1'b0, 1'b0, 1, 1'b1, 1'b1, -1, BIT_CLK);
      repeat (10) @(negedge clk);
      n_cmp++;
      if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL abort_count v%0d: got %0d want %0d", v, obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
        o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
        if (o !== e) begin n_fail++; $display("FAIL abort_word v%0d: got %h/%b/%b want %h/%b/%b", v, o.d, o.fe, o.pe, e.d, e.fe, e.pe); end
      end
    end
  endtask

  task automatic test_back_to_back();
    word_t o, e;
    logic [7:0] words [3];
    words = '{8'h3C, 8'hC3, 8'h81};
    do_reset(0);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back('{d: words[k], fe: 1'b0, pe: 1'b0});
      // first frame's stop bit is cut short so the next start arrives mid-stop
      send_frame(words[k], 1'b0, 1'b0, 1, 1'b1, 1'b1, -1, (k == 0) ? 44 : BIT_CLK);
    end
    repeat (10) @(negedge clk);
    n_cmp++; if (valid_cycles !== 3) begin n_fail++; $display("FAIL b2b_valid: got %0d cycles want 3", valid_cycles); end
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL b2b_word: got %h/%b/%b want %h/%b/%b", o.d, o.fe, o.pe, e.d, e.fe, e.pe); end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_framing();
    test_overrun();
    test_glitch();
    test_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receive engine with these features:
- Internal baud tick generator.
- Configurable oversampling.
- 5..9 data bits, selectable parity (none/even/odd), 1 or 2 stop bits.
- Majority-vote mid-bit sampling.
- Framing, parity and overrun detection.

It sits behind the APB UART interface as the receive path. Received words go to the bus side through a single-entry holding register with a valid/ready handshake.

Parameters:
- CLOCK_RATE, 100000000: system clock frequency in Hz.
- BAUD_RATE, 9600: line rate in bits/s.
- OVERSAMPLE, 16: sample ticks per bit; even, >= 8.
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- PARITY_MODE, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- rx_en  in  1  receiver enable; low aborts any frame in progress
- rxd  in  1  asynchronous serial line, idle high
- rx_data  out  DATA_BITS  received word, LSB = first bit on line
- rx_valid  out  1  holding register full
- rx_ready  in  1  consumer accepts word when rx_valid & rx_ready
- frame_err  out  1  status of held word: a stop bit was sampled 0
- parity_err  out  1  status of held word: parity mismatch; always 0 when PARITY_MODE = 0
- overrun_err  out  1  one-cycle pulse: a completed frame was dropped
- busy  out  1  high in every state except IDLE

Behaviour:
Interface:
- One clock, clk. Reset rst_n is synchronous, active-low, sampled on posedge clk.

Reset (rst_n = 0 at a clk edge):
- State IDLE; all counters 0.
- Synchronizer flops and edge-detect flop preset to 1.
- rx_data = 0; rx_valid, frame_err, parity_err, overrun_err and busy all = 0.
- Reset mid-frame discards the frame; no flag is raised.

Input synchronisation:
- rxd passes through a 2-flop synchronizer; all logic uses the synchronized value.
- Synchronizer latency is 2 cycles.

Tick generator:
- DIV = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE), integer division, minimum 1.
- Divider counter runs 0..DIV-1; a tick is asserted in the cycle the counter equals DIV-1.
- Sample counter runs 0..OVERSAMPLE-1 and advances on each tick; it wraps to 0 at the end of each bit.
- Both counters clear on the start-edge detection cycle, so bit phase aligns to the falling edge.

Sampling:
- Bit value = majority of the 3 synchronized samples taken at sample counts OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
- The bit decision is made on the tick at OVERSAMPLE/2+1.

State machine:
- IDLE: when rx_en = 1 and the synchronized line goes 1 -> 0, go to START.
- START: at the bit decision, majority 1 means a glitch; return to IDLE with no error. Majority 0 means go to DATA at the end of the bit.
- DATA: shift bits in LSB first; after DATA_BITS bits, go to PARITY if PARITY_MODE != 0, else to STOP.
- PARITY: expected parity = XOR of the data bits, inverted when PARITY_MODE = 2; a mismatch sets the internal parity flag.
- STOP: sample each stop bit; any 0 sets the internal frame flag.
  - At the decision tick of the last stop bit, complete the frame and go straight to IDLE without waiting for the bit end.
  - This allows a next start edge from mid-stop-bit onward.

Frame completion (the cycle after the last stop decision):
- If rx_valid = 0 or rx_ready = 1 in that cycle: load rx_data, frame_err and parity_err from the frame and set rx_valid = 1.
- Else: keep the held word, drop the new one, and pulse overrun_err high for exactly 1 cycle.
- rx_valid clears on a cycle where rx_valid & rx_ready & no completion.
- A completion in the same cycle as a read reloads the register and keeps rx_valid = 1.

rx_en low:
- State returns to IDLE on the next edge and the frame in progress is discarded.
- The holding register, rx_valid and status flags are unaffected.
- No new frame starts until rx_en = 1 and a fresh falling edge is seen.

Latency:
- rx_valid rises 1 clk after the last stop-bit decision tick.
- Line-to-start detection adds 3 clk (2 synchronizer + 1 edge register).

Test Plan:
All scenarios use CLOCK_RATE = 640000, BAUD_RATE = 10000, OVERSAMPLE = 16, so DIV = 4 and 1 bit = 64 clk.
1. 8N1 defaults; send 0xA5 with rx_ready = 1 -> rx_valid pulses 1 cycle, rx_data = 0xA5, frame_err = 0, parity_err = 0; busy high from start detect until the stop decision.
2. PARITY_MODE = 1, send 0x03 with parity bit 1 -> parity_err = 1 with rx_data = 0x03. Repeat with parity bit 0 -> parity_err = 0. With PARITY_MODE = 2, parity bit 1 -> parity_err = 0.
3. Stop bit driven 0 on a 0x55 frame -> rx_data = 0x55, frame_err = 1. With STOP_BITS = 2 and only the second stop bit 0 -> frame_err = 1.
4. rx_ready = 0; send 0x11 then 0x22 -> rx_data stays 0x11, overrun_err high exactly 1 cycle at the 0x22 completion. Raising rx_ready then drops rx_valid next cycle.
5. 20-clk low glitch on rxd -> returns to IDLE, no rx_valid, no errors. A 1-clk low sample in mid data bit is filtered by the majority vote, giving the correct word.
6. rx_en dropped, or rst_n = 0, during bit 4 of a frame -> IDLE next cycle, busy = 0, no rx_valid. A subsequent clean 0x7E is received correctly.
